// File: rtl/ifm_feed_ctrl.sv
// ifm_feed_ctrl: fetches IFM rows from SRAM, shifts them into the KW-tap buffer, reports valid windows.
// Latency: SRAM read to buffer shift 1 cycle; window report 1 cycle after the shift that completes it.
// Backpressure: stall blocks read issue; an in-flight sample parks in a skid register until stall drops.
// Ports: start/cfg_* job control (cfg latched on accepted start); stall downstream hold (buf_stall mirrors it);
//        mem_rd_en/mem_addr/mem_rdata SRAM read port (1-cycle read latency); ifm_read/ifm_input buffer drive;
//        win_valid/win_col/win_row/row_last window report; busy/done/cfg_err job status.
module ifm_feed_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12,
   parameter int LEN_W  = 8,
   parameter int ROW_W  = 8,
   parameter int KW     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [LEN_W-1:0]  cfg_row_len,
   input  logic [ROW_W-1:0]  cfg_num_rows,
   input  logic [ADDR_W-1:0] cfg_stride,
   input  logic              stall,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              ifm_read,
   output logic [DATA_W-1:0] ifm_input,
   output logic              buf_stall,
   output logic              win_valid,
   output logic [LEN_W-1:0]  win_col,
   output logic [ROW_W-1:0]  win_row,
   output logic              row_last,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   localparam int FILL_W = $clog2(KW + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_STREAM,
      S_ROW_END,
      S_FIN
   } state_t;

   state_t state, state_nxt;

   // Latched job configuration
   logic [LEN_W-1:0]  row_len_q;
   logic [ROW_W-1:0]  num_rows_q;
   logic [ADDR_W-1:0] stride_q;

   // Row progress
   logic [ADDR_W-1:0] row_base_q;
   logic [ROW_W-1:0]  row_q;
   logic [LEN_W-1:0]  issued_q;
   logic [LEN_W-1:0]  consumed_q;
   logic [FILL_W-1:0] fill_q;

   // Delivery path: rd_q marks SRAM data arriving this cycle, pend marks a sample
   // presented to the buffer but not yet accepted.
   logic              rd_q;
   logic              pend_q;
   logic [DATA_W-1:0] skid_q;

   logic              win_valid_q;
   logic [LEN_W-1:0]  win_col_q;
   logic [ROW_W-1:0]  win_row_q;
   logic              row_last_q;
   logic              cfg_err_q;

   logic consume;
   logic rd_en;
   logic cfg_bad;
   logic rows_left;

   // A presented sample is taken by the buffer on the first cycle without stall.
   assign consume   = pend_q && !stall;
   assign rd_en     = (state == S_STREAM) && (issued_q < row_len_q) && !stall
                      && (!pend_q || consume);
   assign cfg_bad   = (row_len_q < LEN_W'(KW)) || (num_rows_q == '0);
   assign rows_left = (row_q + ROW_W'(1)) < num_rows_q;

   assign mem_rd_en = rd_en;
   assign mem_addr  = row_base_q + ADDR_W'(issued_q);
   assign ifm_read  = pend_q;
   // Fresh SRAM data goes straight through; while stalled it is replayed from the skid.
   assign ifm_input = rd_q ? mem_rdata : skid_q;
   assign buf_stall = stall;
   assign win_valid = win_valid_q;
   assign win_col   = win_col_q;
   assign win_row   = win_row_q;
   assign row_last  = row_last_q;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FIN);
   assign cfg_err   = cfg_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start) state_nxt = S_CHECK;
         S_CHECK:   state_nxt = cfg_bad ? S_FIN : S_STREAM;
         // Exit one cycle after the last consume so the final window is reported in STREAM.
         S_STREAM:  if (consumed_q == row_len_q) state_nxt = S_ROW_END;
         S_ROW_END: state_nxt = rows_left ? S_STREAM : S_FIN;
         S_FIN:     state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_len_q   <= '0;
         num_rows_q  <= '0;
         stride_q    <= '0;
         row_base_q  <= '0;
         row_q       <= '0;
         issued_q    <= '0;
         consumed_q  <= '0;
         fill_q      <= '0;
         rd_q        <= 1'b0;
         pend_q      <= 1'b0;
         skid_q      <= '0;
         win_valid_q <= 1'b0;
         win_col_q   <= '0;
         win_row_q   <= '0;
         row_last_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         rd_q <= rd_en;

         if (rd_en) begin
            pend_q <= 1'b1;
         end else if (consume) begin
            pend_q <= 1'b0;
         end

         if (rd_q && stall) begin
            skid_q <= mem_rdata;
         end

         // fill is cleared per row, so taps left over from the previous row
         // can never complete a window.
         win_valid_q <= 1'b0;
         row_last_q  <= 1'b0;
         if (consume && (fill_q >= FILL_W'(KW - 1))) begin
            win_valid_q <= 1'b1;
            win_col_q   <= consumed_q - LEN_W'(KW - 1);
            win_row_q   <= row_q;
            row_last_q  <= (consumed_q + LEN_W'(1)) == row_len_q;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  row_base_q <= cfg_base;
                  row_len_q  <= cfg_row_len;
                  num_rows_q <= cfg_num_rows;
                  stride_q   <= cfg_stride;
                  cfg_err_q  <= 1'b0;
               end
            end
            S_CHECK: begin
               row_q      <= '0;
               issued_q   <= '0;
               consumed_q <= '0;
               fill_q     <= '0;
               if (cfg_bad) begin
                  cfg_err_q <= 1'b1;
               end
            end
            S_STREAM: begin
               if (rd_en) begin
                  issued_q <= issued_q + LEN_W'(1);
               end
               if (consume) begin
                  consumed_q <= consumed_q + LEN_W'(1);
                  if (fill_q != FILL_W'(KW)) begin
                     fill_q <= fill_q + FILL_W'(1);
                  end
               end
            end
            S_ROW_END: begin
               row_base_q <= row_base_q + stride_q;
               row_q      <= row_q + ROW_W'(1);
               issued_q   <= '0;
               consumed_q <= '0;
               fill_q     <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifm_feed_ctrl.sv
// tb_ifm_feed_ctrl: directed jobs against ifm_feed_ctrl with an SRAM model and event monitor.
// Latency: a job of R rows x L samples finishes 2 + R*(L+3) cycles after start, plus stall cycles.
// Backpressure: one job holds stall for 3 cycles right after its second SRAM read.
module tb_ifm_feed_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] cfg_base = '0;
   logic [7:0]  cfg_row_len = '0;
   logic [7:0]  cfg_num_rows = '0;
   logic [11:0] cfg_stride = '0;
   logic        stall = 1'b0;
   logic        mem_rd_en;
   logic [11:0] mem_addr;
   logic [7:0]  mem_rdata = '0;
   logic        ifm_read;
   logic [7:0]  ifm_input;
   logic        buf_stall;
   logic        win_valid;
   logic [7:0]  win_col;
   logic [7:0]  win_row;
   logic        row_last;
   logic        busy;
   logic        done;
   logic        cfg_err;

   ifm_feed_ctrl #(
      .DATA_W(8), .ADDR_W(12), .LEN_W(8), .ROW_W(8), .KW(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_base(cfg_base), .cfg_row_len(cfg_row_len), .cfg_num_rows(cfg_num_rows),
      .cfg_stride(cfg_stride), .stall(stall),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .ifm_read(ifm_read), .ifm_input(ifm_input), .buf_stall(buf_stall),
      .win_valid(win_valid), .win_col(win_col), .win_row(win_row), .row_last(row_last),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] dat(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
   endfunction

   // SRAM model: one-cycle read latency
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= dat(mem_addr);
   end

   // Event monitor, sampled away from the active edge
   logic [11:0] rd_addr[$];
   int          rd_cyc[$];
   logic [7:0]  cons_dat[$];
   logic [7:0]  stall_dat[$];
   logic [7:0]  wcol[$];
   logic [7:0]  wrow[$];
   bit          wlast[$];
   int          wcyc[$];
   int          rd_in_stall, lone_last, bstall_bad, done_cnt, done_cyc, start_cyc;
   bit          err_at_done;

   always @(negedge clk) begin
      if (rst_n) begin
         if (start && !busy) start_cyc = cyc;
         if (mem_rd_en) begin
            rd_addr.push_back(mem_addr);
            rd_cyc.push_back(cyc);
            if (stall) rd_in_stall++;
         end
         if (ifm_read && !stall) cons_dat.push_back(ifm_input);
         if (ifm_read && stall) stall_dat.push_back(ifm_input);
         if (buf_stall != stall) bstall_bad++;
         if (win_valid) begin
            wcol.push_back(win_col);
            wrow.push_back(win_row);
            wlast.push_back(row_last);
            wcyc.push_back(cyc);
         end
         if (row_last && !win_valid) lone_last++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            err_at_done = cfg_err;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_cfg_err"}, cfg_err, 0);
      check({tag, "_rd_en"}, mem_rd_en, 0);
      check({tag, "_addr"}, mem_addr, 0);
      check({tag, "_ifm_read"}, ifm_read, 0);
      check({tag, "_ifm_input"}, ifm_input, 0);
      check({tag, "_win_valid"}, win_valid, 0);
      check({tag, "_win_col"}, win_col, 0);
      check({tag, "_win_row"}, win_row, 0);
      check({tag, "_row_last"}, row_last, 0);
   endtask

   task automatic clear_monitor();
      rd_addr.delete(); rd_cyc.delete(); cons_dat.delete(); stall_dat.delete();
      wcol.delete(); wrow.delete(); wlast.delete(); wcyc.delete();
      rd_in_stall = 0; lone_last = 0; bstall_bad = 0; done_cnt = 0;
      done_cyc = 0; start_cyc = 0; err_at_done = 1'b0;
   endtask

   // Runs one job to completion and compares every recorded event against
   // values computed from the job parameters.
   task automatic run_job(input string nm, input logic [11:0] base, input int len, input int rows,
                          input logic [11:0] stride, input bit do_stall, input bit poke);
      int n, st_left, nwin, idx, exp_lat;
      bit st_used, bad;
      logic [11:0] ea;
      clear_monitor();
      cfg_base = base; cfg_row_len = 8'(len); cfg_num_rows = 8'(rows); cfg_stride = stride;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // scramble cfg after the start: the job must use its latched copy
      cfg_base = 12'hABC; cfg_row_len = 8'd2; cfg_num_rows = 8'd0; cfg_stride = 12'h007;
      n = 0; st_left = 0; st_used = 1'b0;
      while (done_cnt == 0 && n < 2000) begin
         @(posedge clk); #1;
         n++;
         if (st_left > 0) begin
            st_left--;
            if (st_left == 0) stall = 1'b0;
         end else if (do_stall && !st_used && rd_addr.size() == 2) begin
            stall = 1'b1; st_left = 3; st_used = 1'b1;
         end
         start = (poke && n == 6);
      end
      start = 1'b0;
      stall = 1'b0;
      @(posedge clk); #1;
      check({nm, "_done_pulses"}, done_cnt, 1);
      check({nm, "_busy_after"}, busy, 0);
      check({nm, "_buf_stall"}, bstall_bad, 0);
      check({nm, "_lone_last"}, lone_last, 0);
      bad = (len < 4) || (rows == 0);
      if (bad) begin
         check({nm, "_cfg_err"}, err_at_done, 1);
         check({nm, "_latency"}, done_cyc - start_cyc, 2);
         check({nm, "_reads"}, rd_addr.size(), 0);
         check({nm, "_wins"}, wcol.size(), 0);
      end else begin
         exp_lat = 2 + rows * (len + 3) + (do_stall ? 3 : 0);
         check({nm, "_cfg_err"}, err_at_done, 0);
         check({nm, "_latency"}, done_cyc - start_cyc, exp_lat);
         check({nm, "_reads"}, rd_addr.size(), rows * len);
         check({nm, "_cons"}, cons_dat.size(), rows * len);
         for (int r = 0; r < rows; r++) begin
            for (int i = 0; i < len; i++) begin
               idx = r * len + i;
               ea = base + stride * 12'(r) + 12'(i);
               if (idx < rd_addr.size())
                  check($sformatf("%s_addr_r%0d_c%0d", nm, r, i), rd_addr[idx], ea);
               if (idx < cons_dat.size())
                  check($sformatf("%s_data_r%0d_c%0d", nm, r, i), cons_dat[idx], dat(ea));
               if (!do_stall && idx < rd_cyc.size())
                  check($sformatf("%s_rdcyc_r%0d_c%0d", nm, r, i), rd_cyc[idx] - rd_cyc[r * len], i);
            end
         end
         nwin = len - 3;
         check({nm, "_wins"}, wcol.size(), rows * nwin);
         for (int r = 0; r < rows; r++) begin
            for (int k = 0; k < nwin; k++) begin
               idx = r * nwin + k;
               if (idx < wcol.size()) begin
                  check($sformatf("%s_wcol_%0d", nm, idx), wcol[idx], k);
                  check($sformatf("%s_wrow_%0d", nm, idx), wrow[idx], r);
                  check($sformatf("%s_wlast_%0d", nm, idx), wlast[idx], (k == nwin - 1));
               end
            end
         end
         // last window sits in the final STREAM cycle, then ROW_END, then FIN
         if (wcyc.size() > 0)
            check({nm, "_done_after_last"}, done_cyc - wcyc[wcyc.size() - 1], 2);
         if (do_stall) begin
            check({nm, "_stall_cycles"}, stall_dat.size(), 3);
            for (int i = 0; i < stall_dat.size(); i++)
               check($sformatf("%s_skid_%0d", nm, i), stall_dat[i], dat(base + 12'd1));
            check({nm, "_rd_in_stall"}, rd_in_stall, 0);
         end
      end
   endtask

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_job("t1_basic", 12'h010, 6, 1, 12'h000, 1'b0, 1'b0);
      run_job("t2_rows", 12'h100, 4, 3, 12'h020, 1'b0, 1'b1);
      run_job("t3_stall", 12'h300, 6, 1, 12'h000, 1'b1, 1'b0);
      run_job("t4_short", 12'h050, 3, 2, 12'h010, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("t4_err_sticky", cfg_err, 1);
      run_job("t4_norows", 12'h050, 6, 0, 12'h010, 1'b0, 1'b0);
      run_job("t5_wrap", 12'hFFE, 4, 1, 12'h000, 1'b0, 1'b0);

      // mid-row reset
      clear_monitor();
      cfg_base = 12'h020; cfg_row_len = 8'd8; cfg_num_rows = 8'd2; cfg_stride = 12'h040;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (rd_addr.size() < 3 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("t6_reached_mid_row", rd_addr.size() >= 3, 1);
      rst_n = 1'b0;
      #2;
      check_zero_outputs("t6_mid_reset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("t6_no_done_after_abort", done_cnt, 0);
      check("t6_idle_after_abort", busy, 0);
      run_job("t6_restart", 12'h200, 4, 1, 12'h000, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
